// File: rtl/change_payout_ctrl.sv
// Coin-change payout controller: greedy 10/5 yuan hopper sequencing
// with per-coin drop acknowledge timeout and latched fault.
module change_payout_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [5:0] req_amount,
  output logic       req_ready,
  output logic       req_err,
  input  logic       hop10_empty,
  input  logic       hop5_empty,
  output logic       hop10_pulse,
  output logic       hop5_pulse,
  input  logic       hop10_ack,
  input  logic       hop5_ack,
  input  logic       clear_fault,
  output logic       done,
  output logic       fault,
  output logic [5:0] remaining,
  output logic [5:0] paid
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_FIRE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [5:0]      r_rem;
  logic [5:0]      r_paid;
  logic [TW-1:0]   r_timer;
  logic            r_sel10;
  logic            r_err;

  logic            w_hs;
  logic            w_ok;
  logic            w_can10;
  logic            w_can5;
  logic            w_ack;
  logic [5:0]      w_coin;

  assign w_hs    = req_valid && (r_state == S_IDLE);
  assign w_ok    = ((req_amount % 6'd5) == 6'd0);
  assign w_can10 = (r_rem >= 6'd10) && !hop10_empty;
  assign w_can5  = (r_rem >= 6'd5) && !hop5_empty;
  assign w_coin  = r_sel10 ? 6'd10 : 6'd5;
  // only the selected hopper's sensor counts, and only while waiting
  assign w_ack   = (r_state == S_WAIT) &&
                   (r_sel10 ? hop10_ack : hop5_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs && w_ok) w_next = S_SEL;
      end
      S_SEL: begin
        if (r_rem == 6'd0)         w_next = S_DONE;
        else if (w_can10 || w_can5) w_next = S_FIRE;
        else                        w_next = S_FAULT;
      end
      S_FIRE: w_next = S_WAIT;
      S_WAIT: begin
        if (w_ack)                 w_next = S_SEL;
        else if (r_timer == '0)    w_next = S_FAULT;
      end
      S_DONE: w_next = S_IDLE;
      S_FAULT: begin
        if (clear_fault) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_paid  <= '0;
      r_timer <= '0;
      r_sel10 <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_hs && !w_ok;
      if (w_hs && w_ok) begin
        r_rem  <= req_amount;
        r_paid <= '0;
      end
      if (r_state == S_SEL) r_sel10 <= w_can10;
      if (r_state == S_FIRE) r_timer <= TW'(TIMEOUT);
      if (r_state == S_WAIT) begin
        if (w_ack) begin
          r_rem  <= r_rem - w_coin;
          r_paid <= r_paid + w_coin;
        end else if (r_timer != '0) begin
          r_timer <= r_timer - TW'(1);
        end
      end
    end
  end

  always_comb begin
    req_ready   = (r_state == S_IDLE);
    req_err     = r_err;
    hop10_pulse = (r_state == S_FIRE) && r_sel10;
    hop5_pulse  = (r_state == S_FIRE) && !r_sel10;
    done        = (r_state == S_DONE);
    fault       = (r_state == S_FAULT);
    remaining   = r_rem;
    paid        = r_paid;
  end

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Randomized bench for change_payout_ctrl against a greedy
// coin-list reference model with random acknowledge timing.
module tb_change_payout_ctrl;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_amount = '0;
  logic       req_ready;
  logic       req_err;
  logic       hop10_empty = 1'b0;
  logic       hop5_empty = 1'b0;
  logic       hop10_pulse;
  logic       hop5_pulse;
  logic       hop10_ack = 1'b0;
  logic       hop5_ack = 1'b0;
  logic       clear_fault = 1'b0;
  logic       done;
  logic       fault;
  logic [5:0] remaining;
  logic [5:0] paid;

  int n_vec = 0;
  int n_err = 0;

  change_payout_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_amount(req_amount),
    .req_ready(req_ready),
    .req_err(req_err),
    .hop10_empty(hop10_empty),
    .hop5_empty(hop5_empty),
    .hop10_pulse(hop10_pulse),
    .hop5_pulse(hop5_pulse),
    .hop10_ack(hop10_ack),
    .hop5_ack(hop5_ack),
    .clear_fault(clear_fault),
    .done(done),
    .fault(fault),
    .remaining(remaining),
    .paid(paid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_err"}, req_err, 0);
    chk({tag, "_p10"}, hop10_pulse, 0);
    chk({tag, "_p5"}, hop5_pulse, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_rem"}, remaining, 0);
    chk({tag, "_paid"}, paid, 0);
  endtask

  // hold_idx: coin index whose ack is withheld (-1 none)
  // fix_k: ack in this wait cycle (0 = random 1..T+1)
  task automatic run_txn(input int amt, input bit e10, input bit e5,
                         input int hold_idx, input int fix_k);
    int  coins[$];
    int  r;
    int  paid_m;
    int  c;
    int  idx;
    int  wait_n;
    int  k;
    bit  exp_fault;
    bit  pend;
    bit  sel10;
    bit  fin;
    bit  hit;

    r = amt;
    if (amt % 5 == 0) begin
      while (r > 0) begin
        if (r >= 10 && !e10) begin
          coins.push_back(10);
          r -= 10;
        end else if (r >= 5 && !e5) begin
          coins.push_back(5);
          r -= 5;
        end else begin
          break;
        end
      end
    end
    exp_fault = (r != 0) ||
                (hold_idx >= 0 && hold_idx < coins.size());

    hop10_empty = e10;
    hop5_empty  = e5;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_amount = amt[5:0];
    @(negedge clk);
    req_valid = 1'b0;

    if (amt % 5 != 0) begin
      chk("req_err", req_err, 1);
      chk("ready_err", req_ready, 1);
      chk("err_nopulse", hop10_pulse | hop5_pulse, 0);
      @(negedge clk);
      chk("req_err_end", req_err, 0);
      chk("ready_after_err", req_ready, 1);
      chk("err_nopulse2", hop10_pulse | hop5_pulse, 0);
      return;
    end

    chk("err_quiet", req_err, 0);
    paid_m = 0;
    idx    = 0;
    c      = 1;
    pend   = 0;
    fin    = 0;
    wait_n = 0;
    k      = -1;
    sel10  = 0;
    while (!fin && c < 1000) begin
      if (hop10_pulse && hop5_pulse) chk("dual_pulse", 1, 0);
      if (int'(remaining) + int'(paid) != amt)
        chk("sum_inv", int'(remaining) + int'(paid), amt);
      if (hop10_pulse || hop5_pulse) begin
        chk("coin", hop10_pulse ? 10 : 5,
            idx < coins.size() ? coins[idx] : 0);
        chk("pulse_while_busy", pend, 0);
        if (idx == 0) chk("first_pulse_lat", c, 2);
        chk("paid_at_pulse", paid, paid_m);
        sel10  = hop10_pulse;
        k      = (idx == hold_idx) ? -1 :
                 (fix_k > 0 ? fix_k : int'($urandom_range(1, T + 1)));
        wait_n = 0;
        pend   = 1;
      end
      if (done) begin
        chk("done_exp", exp_fault, 0);
        chk("done_coins", idx, coins.size());
        chk("done_paid", paid, amt);
        chk("done_rem", remaining, 0);
        if (amt == 0) chk("zero_lat", c, 2);
        fin = 1;
      end
      if (fault) begin
        chk("fault_exp", exp_fault, 1);
        chk("fault_rem", remaining, amt - paid_m);
        chk("fault_paid", paid, paid_m);
        if (pend) chk("timeout_lat", wait_n, T + 2);
        else      chk("stock_fault", idx, coins.size());
        fin = 1;
      end
      if (!fin) begin
        if (pend) begin
          hit = (wait_n == k);
          if (sel10) begin
            hop10_ack = hit || (wait_n == 0 && $urandom_range(0, 1) == 1);
            hop5_ack  = $urandom_range(0, 1) == 1;
          end else begin
            hop5_ack  = hit || (wait_n == 0 && $urandom_range(0, 1) == 1);
            hop10_ack = $urandom_range(0, 1) == 1;
          end
          if (hit) begin
            paid_m += coins[idx];
            idx++;
            pend = 0;
          end
          wait_n++;
        end else begin
          hop10_ack = $urandom_range(0, 1) == 1;
          hop5_ack  = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
        c++;
      end
    end
    hop10_ack = 1'b0;
    hop5_ack  = 1'b0;
    if (!fin) begin
      chk("txn_timeout", 0, 1);
    end else if (fault) begin
      repeat (2) begin
        @(negedge clk);
        chk("fault_hold", fault, 1);
        chk("fault_nopulse", hop10_pulse | hop5_pulse, 0);
      end
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
      chk("cleared", fault, 0);
      chk("ready_clear", req_ready, 1);
      chk("rem_clear", remaining, amt - paid_m);
      chk("paid_clear", paid, paid_m);
    end else begin
      @(negedge clk);
      chk("done_once", done, 0);
      chk("ready_done", req_ready, 1);
      chk("paid_hold", paid, amt);
    end
  endtask

  task automatic reset_mid_payout();
    int n;
    int extra;
    hop10_empty = 1'b0;
    hop5_empty  = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = 6'd30;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!hop10_pulse && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_txn_pulse", hop10_pulse, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    hop10_ack = 1'b1;
    @(negedge clk);
    chk_reset_outs("in_rst");
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (hop10_pulse || hop5_pulse) extra++;
    end
    hop10_ack = 1'b0;
    chk("rst_no_pulses", extra, 0);
    chk_reset_outs("post_rst");
  endtask

  initial begin
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(15, 0, 0, -1, 1);
    run_txn(20, 1, 0, -1, 1);
    run_txn(7, 0, 0, -1, 0);
    run_txn(10, 0, 0, 0, 0);
    run_txn(10, 1, 1, -1, 0);
    run_txn(0, 0, 0, -1, 0);
    run_txn(10, 0, 0, -1, T + 1);
    run_txn(63, 0, 0, -1, 0);
    reset_mid_payout();

    repeat (80) begin
      int a;
      int h;
      bit x;
      bit y;
      if ($urandom_range(0, 3) != 0) a = 5 * int'($urandom_range(0, 12));
      else                           a = int'($urandom_range(0, 63));
      x = ($urandom_range(0, 4) == 0);
      y = ($urandom_range(0, 4) == 0);
      h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_txn(a, x, y, h, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
